dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Arbitrates the single-port, synchronous-read variable data memory (128 words at byte address 0x800–0x9FC) between the ARM core data port and the IO/debug read port that drives the seven-segment display. The block sits between the core and the memory array.
- The core has fixed priority.
- A bounded-wait counter guarantees the IO port a slot.
- The core is stalled only in the cycle the IO port is forced through.

## Interface
Parameters:
- ADDR_W, 7, word-index width of the memory (depth 2^ADDR_W)
- BASE, 32'h00000800, byte base address of the variable memory
- MAX_WAIT, 4, cycles the IO port may be refused before it is forced; 0 means the IO port always wins

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CPU_REQ  in  1  core requests a data access this cycle
- CPU_WE  in  1  1 = write, 0 = read
- CPU_ADDR  in  32  byte address (the ALU result)
- CPU_WDATA  in  32  write data
- CPU_STALL  out  1  core must hold its request unchanged this cycle
- CPU_RDATA  out  32  read data
- CPU_RVALID  out  1  CPU_RDATA valid this cycle
- IO_REQ  in  1  IO read request, held until granted
- IO_ADDR  in  ADDR_W  IO word index (the DIP value)
- IO_GNT  out  1  IO request accepted this cycle
- IO_RDATA  out  32  IO read data
- IO_RVALID  out  1  IO_RDATA valid this cycle
- MEM_EN, MEM_WE  out  1  memory enable and write enable
- MEM_ADDR  out  ADDR_W  memory word index
- MEM_WDATA  out  32  memory write data
- MEM_RDATA  in  32  memory read data, valid one cycle after MEM_EN with MEM_WE=0

## Operation
- A CPU request is in range when CPU_ADDR is 4-byte aligned and BASE ≤ CPU_ADDR ≤ BASE+4·(2^ADDR_W)−4. Its word index is (CPU_ADDR−BASE)>>2.
- Out-of-range CPU request:
  - never touches the memory and never stalls;
  - a read returns RDATA=0 with RVALID the next cycle;
  - a write is dropped.
- Force condition: force = IO_REQ && (wait_cnt ≥ MAX_WAIT).
- Grant per cycle, exactly one of:
  - CPU — when the CPU request is in range and force is low; wait_cnt increments if IO_REQ is high.
  - IO — when force is high, or when there is no in-range CPU request; IO_GNT=1, wait_cnt clears, and CPU_STALL=1 if an in-range CPU request exists.
  - none — MEM_EN=0.
- wait_cnt:
  - clears whenever IO_REQ=0;
  - saturates at MAX_WAIT;
  - width is clog2(MAX_WAIT+1) (1 bit minimum).
- owner register: {NONE, CPU, CPU_OOR, IO}, loaded every cycle with the winner of the previous cycle's grant; selects which RDATA/RVALID pair fires.
- A write grant loads owner NONE: writes produce no RVALID.
- The IO port is read-only.
- MEM_* outputs are combinational from the grant decision; MEM_WDATA = CPU_WDATA.

## Timing
- Read latency is 1 cycle after grant.
  - CPU_RDATA = MEM_RDATA (0 for CPU_OOR) when owner is CPU or CPU_OOR; otherwise 0.
  - IO_RDATA = MEM_RDATA when owner=IO; otherwise holds its last value (registered capture).
- A write commits at the edge ending the grant cycle.
- A stalled core re-presents the same request next cycle. Because wait_cnt is now 0, the core wins that cycle. Worst-case CPU delay is 1 cycle.
- Worst-case IO wait: MAX_WAIT+1 cycles from IO_REQ rise to IO_GNT.
- Reset values:
  - all outputs 0;
  - wait_cnt=0, owner=NONE, IO_RDATA register 0.
- Reset asserted mid-access: a pending RVALID is cancelled; any in-flight write is the memory's responsibility.
- Simultaneous CPU write and IO read to the same word in the force cycle: the IO read executes first, then the write the next cycle. The IO port sees old data.

## Structure
- Package dmem_pkg holds:
  - BASE and depth constants;
  - owner_t enum {OWN_NONE, OWN_CPU, OWN_CPU_OOR, OWN_IO}.
- One sub-module, dmem_addr_dec: combinational range/alignment check and word-index computation, reusable for the constant memory decode.

## Test plan
- CPU read 0x804 with memory word 1 = 0xDEADBEEF → cycle+1: CPU_RVALID=1, CPU_RDATA=0xDEADBEEF; no stall.
- IO_REQ with IO_ADDR=5 while the core is idle → IO_GNT the same cycle; IO_RVALID the next cycle with word 5.
- CPU requests every cycle, IO_REQ held high, MAX_WAIT=4 → CPU wins 4 cycles; in the 5th, IO_GNT=1 and CPU_STALL=1; CPU wins in the 6th.
- CPU write 0x900=0x12345678, then IO read index 64 → IO_RDATA=0x12345678.
- CPU read 0x200 (out of range) → MEM_EN=0, CPU_RDATA=0 with RVALID; CPU write 0x9FE (unaligned) → dropped, memory unchanged.
- RESET_N pulsed low in the cycle after a CPU read grant → CPU_RVALID stays 0; all outputs 0 until the next request.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and types for the variable data memory and its port arbiter.
package dmem_pkg;

  // Default word-index width of the variable memory (128 words).
  localparam int unsigned DMEM_ADDR_W = 7;

  // Number of 32-bit words in the variable memory.
  localparam int unsigned DMEM_DEPTH = 1 << DMEM_ADDR_W;

  // Byte address of word 0 of the variable memory.
  localparam logic [31:0] DMEM_BASE = 32'h0000_0800;

  // Default number of cycles the IO port may be refused before it is forced.
  localparam int unsigned DMEM_MAX_WAIT = 4;

  // Which port's read data is returned in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_CPU     = 2'd1,
    OWN_CPU_OOR = 2'd2,
    OWN_IO      = 2'd3
  } owner_t;

  // True when a byte address points at the start of a 32-bit word.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_addr_dec.sv
// Range/alignment check and word-index computation for a memory window of
// 2^ADDR_W words starting at byte address BASE. Purely combinational, so the
// same decoder can serve the constant memory with different parameters.
module dmem_addr_dec
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter logic [31:0] BASE   = DMEM_BASE
) (
  input  logic [31:0]       addr_i,
  output logic              in_range_o,
  output logic [ADDR_W-1:0] idx_o
);

  // Byte address of the last word in the window, kept 33 bits wide so a
  // window touching the top of the address space cannot wrap.
  localparam logic [32:0] LAST_ADDR = {1'b0, BASE} + (33'd1 << (ADDR_W + 2)) - 33'd4;

  logic [31:0] offset_s;
  logic        unused_offset_s;

  // Offset from the window base, word index, and in-range decision.
  always_comb begin
    offset_s   = addr_i - BASE;
    idx_o      = offset_s[ADDR_W+1:2];
    in_range_o = is_word_aligned(addr_i) &&
                 (addr_i >= BASE) &&
                 ({1'b0, addr_i} <= LAST_ADDR);
  end

  // Offset bits outside the word index only matter through in_range_o.
  assign unused_offset_s = ^{offset_s[31:ADDR_W+2], offset_s[1:0]};

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter for the single-port, synchronous-read variable data memory shared by
// the core data port (fixed priority) and the read-only IO/debug port. A
// saturating wait counter forces the IO port through after MAX_WAIT refusals;
// only in that forced cycle is the core stalled.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter logic [31:0] BASE     = DMEM_BASE,
  parameter int unsigned MAX_WAIT = DMEM_MAX_WAIT
) (
  input  logic              CLK,
  input  logic              RESET_N,
  // core data port
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [31:0]       CPU_ADDR,
  input  logic [31:0]       CPU_WDATA,
  output logic              CPU_STALL,
  output logic [31:0]       CPU_RDATA,
  output logic              CPU_RVALID,
  // IO/debug read port
  input  logic              IO_REQ,
  input  logic [ADDR_W-1:0] IO_ADDR,
  output logic              IO_GNT,
  output logic [31:0]       IO_RDATA,
  output logic              IO_RVALID,
  // memory array port
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE_C = WAIT_W'(1);

  // decoded core address
  logic              cpu_in_range_s;
  logic [ADDR_W-1:0] cpu_idx_s;

  // grant decision
  logic cpu_inr_s;
  logic cpu_oor_rd_s;
  logic force_s;
  logic grant_cpu_s;
  logic grant_io_s;

  // state
  logic [WAIT_W-1:0] wait_d, wait_q;
  owner_t            owner_d, owner_q;
  logic              oor_d, oor_q;
  logic [31:0]       io_rdata_d, io_rdata_q;

  dmem_addr_dec #(
    .ADDR_W (ADDR_W),
    .BASE   (BASE)
  ) u_cpu_dec (
    .addr_i     (CPU_ADDR),
    .in_range_o (cpu_in_range_s),
    .idx_o      (cpu_idx_s)
  );

  // Decide which port owns the memory this cycle.
  always_comb begin
    cpu_inr_s    = CPU_REQ & cpu_in_range_s;
    cpu_oor_rd_s = CPU_REQ & ~cpu_in_range_s & ~CPU_WE;
    force_s      = IO_REQ & (wait_q >= MAX_WAIT_C);
    grant_cpu_s  = cpu_inr_s & ~force_s;
    grant_io_s   = IO_REQ & (force_s | ~cpu_inr_s);
  end

  // Drive the memory port and core stall straight from the grant.
  always_comb begin
    MEM_EN    = grant_cpu_s | grant_io_s;
    MEM_WE    = grant_cpu_s & CPU_WE;
    MEM_WDATA = CPU_WDATA;
    IO_GNT    = grant_io_s;
    CPU_STALL = grant_io_s & cpu_inr_s;
    if (grant_io_s) begin
      MEM_ADDR = IO_ADDR;
    end else if (grant_cpu_s) begin
      MEM_ADDR = cpu_idx_s;
    end else begin
      MEM_ADDR = {ADDR_W{1'b0}};
    end
  end

  // Next wait count, owner and IO capture. An out-of-range core read that
  // coincides with an IO grant is tracked separately so neither response is
  // lost (the two never compete for the memory).
  always_comb begin
    wait_d     = wait_q;
    owner_d    = OWN_NONE;
    oor_d      = 1'b0;
    io_rdata_d = io_rdata_q;

    if (!IO_REQ) begin
      wait_d = {WAIT_W{1'b0}};
    end else if (grant_io_s) begin
      wait_d = {WAIT_W{1'b0}};
    end else if (wait_q < MAX_WAIT_C) begin
      wait_d = wait_q + WAIT_ONE_C;
    end else begin
      wait_d = wait_q;
    end

    if (grant_io_s) begin
      owner_d = OWN_IO;
      oor_d   = cpu_oor_rd_s;
    end else if (grant_cpu_s) begin
      owner_d = CPU_WE ? OWN_NONE : OWN_CPU;
    end else if (cpu_oor_rd_s) begin
      owner_d = OWN_CPU_OOR;
    end else begin
      owner_d = OWN_NONE;
    end

    if (owner_q == OWN_IO) begin
      io_rdata_d = MEM_RDATA;
    end else begin
      io_rdata_d = io_rdata_q;
    end
  end

  // Route the read response of the previous cycle's winner.
  always_comb begin
    CPU_RDATA  = 32'h0000_0000;
    CPU_RVALID = oor_q;
    IO_RDATA   = io_rdata_q;
    IO_RVALID  = 1'b0;
    case (owner_q)
      OWN_CPU: begin
        CPU_RDATA  = MEM_RDATA;
        CPU_RVALID = 1'b1;
      end
      OWN_CPU_OOR: begin
        CPU_RDATA  = 32'h0000_0000;
        CPU_RVALID = 1'b1;
      end
      OWN_IO: begin
        IO_RDATA  = MEM_RDATA;
        IO_RVALID = 1'b1;
      end
      OWN_NONE: begin
        CPU_RDATA = 32'h0000_0000;
      end
      default: begin
        CPU_RDATA  = 32'h0000_0000;
        CPU_RVALID = 1'b0;
      end
    endcase
  end

  // Arbitration state; reset cancels any pending read response.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wait_q     <= {WAIT_W{1'b0}};
      owner_q    <= OWN_NONE;
      oor_q      <= 1'b0;
      io_rdata_q <= 32'h0000_0000;
    end else begin
      wait_q     <= wait_d;
      owner_q    <= owner_d;
      oor_q      <= oor_d;
      io_rdata_q <= io_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a behavioural
// single-port synchronous-read memory attached to the MEM_* port.
module tb_dmem_port_arbiter;

  localparam int unsigned ADDR_W = 7;

  logic              CLK;
  logic              RESET_N;
  logic              CPU_REQ;
  logic              CPU_WE;
  logic [31:0]       CPU_ADDR;
  logic [31:0]       CPU_WDATA;
  logic              CPU_STALL;
  logic [31:0]       CPU_RDATA;
  logic              CPU_RVALID;
  logic              IO_REQ;
  logic [ADDR_W-1:0] IO_ADDR;
  logic              IO_GNT;
  logic [31:0]       IO_RDATA;
  logic              IO_RVALID;
  logic              MEM_EN;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_WDATA;
  logic [31:0]       MEM_RDATA;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int n_assert = 0;
  int n_fail   = 0;

  dmem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .BASE     (32'h0000_0800),
    .MAX_WAIT (4)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .CPU_REQ    (CPU_REQ),
    .CPU_WE     (CPU_WE),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_WDATA  (CPU_WDATA),
    .CPU_STALL  (CPU_STALL),
    .CPU_RDATA  (CPU_RDATA),
    .CPU_RVALID (CPU_RVALID),
    .IO_REQ     (IO_REQ),
    .IO_ADDR    (IO_ADDR),
    .IO_GNT     (IO_GNT),
    .IO_RDATA   (IO_RDATA),
    .IO_RVALID  (IO_RVALID),
    .MEM_EN     (MEM_EN),
    .MEM_WE     (MEM_WE),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WDATA  (MEM_WDATA),
    .MEM_RDATA  (MEM_RDATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural memory: synchronous read, write commits at the clock edge.
  always @(posedge CLK) begin
    if (MEM_EN) begin
      if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
      else        MEM_RDATA <= mem[MEM_ADDR];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    CPU_REQ   = req;
    CPU_WE    = we;
    CPU_ADDR  = addr;
    CPU_WDATA = wd;
  endtask

  initial begin
    RESET_N = 1'b0;
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    IO_REQ  = 1'b0;
    IO_ADDR = 7'd0;
    #2;
    chk("rst_cpu_stall",  {31'd0, CPU_STALL},  32'd0);
    chk("rst_cpu_rdata",  CPU_RDATA,           32'd0);
    chk("rst_cpu_rvalid", {31'd0, CPU_RVALID}, 32'd0);
    chk("rst_io_gnt",     {31'd0, IO_GNT},     32'd0);
    chk("rst_io_rdata",   IO_RDATA,            32'd0);
    chk("rst_io_rvalid",  {31'd0, IO_RVALID},  32'd0);
    chk("rst_mem_en",     {31'd0, MEM_EN},     32'd0);
    chk("rst_mem_we",     {31'd0, MEM_WE},     32'd0);
    chk("rst_mem_addr",   {25'd0, MEM_ADDR},   32'd0);
    cyc();
    cyc();
    RESET_N = 1'b1;

    // Preload words 1, 5 and 127 through the core port.
    cpu(1'b1, 1'b1, 32'h0000_0804, 32'hDEAD_BEEF);
    #3;
    chk("pre_w1_we",   {31'd0, MEM_WE},   32'd1);
    chk("pre_w1_addr", {25'd0, MEM_ADDR}, 32'd1);
    cyc();
    cpu(1'b1, 1'b1, 32'h0000_0814, 32'h5555_5555);
    cyc();
    cpu(1'b1, 1'b1, 32'h0000_09FC, 32'h7F7F_7F7F);
    #3;
    chk("pre_w127_addr", {25'd0, MEM_ADDR}, 32'd127);
    chk("pre_w127_en",   {31'd0, MEM_EN},   32'd1);
    cyc();
    chk("write_no_rvalid", {31'd0, CPU_RVALID}, 32'd0);

    // Core read of 0x804.
    cpu(1'b1, 1'b0, 32'h0000_0804, 32'h0);
    #3;
    chk("rd804_en",    {31'd0, MEM_EN},    32'd1);
    chk("rd804_we",    {31'd0, MEM_WE},    32'd0);
    chk("rd804_stall", {31'd0, CPU_STALL}, 32'd0);
    cyc();
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd804_rvalid", {31'd0, CPU_RVALID}, 32'd1);
    chk("rd804_rdata",  CPU_RDATA,           32'hDEAD_BEEF);
    #3;
    chk("idle_en", {31'd0, MEM_EN}, 32'd0);

    // IO read of word 5 with the core idle.
    IO_REQ  = 1'b1;
    IO_ADDR = 7'd5;
    #3;
    chk("io5_gnt",  {31'd0, IO_GNT},   32'd1);
    chk("io5_addr", {25'd0, MEM_ADDR}, 32'd5);
    cyc();
    IO_REQ = 1'b0;
    chk("io5_rvalid",     {31'd0, IO_RVALID},  32'd1);
    chk("io5_rdata",      IO_RDATA,            32'h5555_5555);
    chk("io5_cpu_rvalid", {31'd0, CPU_RVALID}, 32'd0);
    cyc();
    chk("io5_rvalid_off", {31'd0, IO_RVALID}, 32'd0);
    chk("io5_rdata_held", IO_RDATA,           32'h5555_5555);

    // Core hammers word 1 while IO waits: forced through on the 5th cycle.
    cpu(1'b1, 1'b0, 32'h0000_0804, 32'h0);
    IO_REQ  = 1'b1;
    IO_ADDR = 7'd5;
    for (int c = 0; c < 6; c++) begin
      #3;
      chk($sformatf("bw%0d_gnt", c),   {31'd0, IO_GNT},    (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("bw%0d_stall", c), {31'd0, CPU_STALL}, (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("bw%0d_addr", c),  {25'd0, MEM_ADDR},  (c == 4) ? 32'd5 : 32'd1);
      cyc();
      chk($sformatf("bw%0d_cpu_rv", c), {31'd0, CPU_RVALID}, (c == 4) ? 32'd0 : 32'd1);
      chk($sformatf("bw%0d_io_rv", c),  {31'd0, IO_RVALID},  (c == 4) ? 32'd1 : 32'd0);
      if (c == 4) IO_REQ = 1'b0;
    end
    chk("bw_cpu_rdata", CPU_RDATA, 32'hDEAD_BEEF);
    cpu(1'b0, 1'b0, 32'h0, 32'h0);

    // Core writes 0x900, IO then reads word 64.
    cpu(1'b1, 1'b1, 32'h0000_0900, 32'h1234_5678);
    #3;
    chk("w900_we",   {31'd0, MEM_WE},   32'd1);
    chk("w900_addr", {25'd0, MEM_ADDR}, 32'd64);
    cyc();
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    IO_REQ  = 1'b1;
    IO_ADDR = 7'd64;
    chk("w900_no_rvalid", {31'd0, CPU_RVALID}, 32'd0);
    #3;
    chk("io64_gnt", {31'd0, IO_GNT}, 32'd1);
    cyc();
    IO_REQ = 1'b0;
    chk("io64_rvalid", {31'd0, IO_RVALID}, 32'd1);
    chk("io64_rdata",  IO_RDATA,           32'h1234_5678);

    // Out-of-range read, unaligned write, window edges.
    cpu(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    #3;
    chk("oor200_en",    {31'd0, MEM_EN},    32'd0);
    chk("oor200_stall", {31'd0, CPU_STALL}, 32'd0);
    cyc();
    chk("oor200_rvalid", {31'd0, CPU_RVALID}, 32'd1);
    chk("oor200_rdata",  CPU_RDATA,           32'd0);
    cpu(1'b1, 1'b1, 32'h0000_09FE, 32'hAAAA_5555);
    #3;
    chk("una9fe_en", {31'd0, MEM_EN}, 32'd0);
    cyc();
    chk("una9fe_no_rvalid", {31'd0, CPU_RVALID}, 32'd0);
    cpu(1'b1, 1'b0, 32'h0000_0A00, 32'h0);
    #3;
    chk("oorA00_en", {31'd0, MEM_EN}, 32'd0);
    cpu(1'b1, 1'b0, 32'h0000_07FC, 32'h0);
    #3;
    chk("oor7FC_en", {31'd0, MEM_EN}, 32'd0);
    cyc();
    cpu(1'b1, 1'b0, 32'h0000_09FC, 32'h0);
    #3;
    chk("rd9FC_en",   {31'd0, MEM_EN},   32'd1);
    chk("rd9FC_addr", {25'd0, MEM_ADDR}, 32'd127);
    cyc();
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd9FC_rvalid", {31'd0, CPU_RVALID}, 32'd1);
    chk("rd9FC_rdata",  CPU_RDATA,           32'h7F7F_7F7F);

    // Reset across the edge that would deliver a read response.
    cyc();
    cpu(1'b1, 1'b0, 32'h0000_0804, 32'h0);
    #3;
    chk("rstrd_en", {31'd0, MEM_EN}, 32'd1);
    RESET_N = 1'b0;
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    chk("rstrd_cpu_rvalid", {31'd0, CPU_RVALID}, 32'd0);
    chk("rstrd_cpu_rdata",  CPU_RDATA,           32'd0);
    chk("rstrd_io_rdata",   IO_RDATA,            32'd0);
    chk("rstrd_io_rvalid",  {31'd0, IO_RVALID},  32'd0);
    chk("rstrd_mem_en",     {31'd0, MEM_EN},     32'd0);
    chk("rstrd_stall",      {31'd0, CPU_STALL},  32'd0);
    chk("rstrd_io_gnt",     {31'd0, IO_GNT},     32'd0);
    RESET_N = 1'b1;
    cyc();
    chk("post_rst_cpu_rvalid", {31'd0, CPU_RVALID}, 32'd0);
    chk("post_rst_io_rdata",   IO_RDATA,            32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
